// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, writeback slot record and requester enum for the register-file write arbiter
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_slot_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback requests, register-file write port and decode read/hazard signals
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_wdata;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_wdata;

    logic              rf_en;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;

    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rdata1_in;
    logic [DATA_W-1:0] rdata2_in;
    logic [DATA_W-1:0] rdata1_out;
    logic [DATA_W-1:0] rdata2_out;
    logic              rs1_pend;
    logic              rs2_pend;

    modport master (
        output alu_valid, alu_rd, alu_wdata,
        output lsu_valid, lsu_rd, lsu_wdata,
        output rs1, rs2, rdata1_in, rdata2_in,
        input  alu_ready, lsu_ready,
        input  rf_en, rf_rd, rf_wdata,
        input  rdata1_out, rdata2_out, rs1_pend, rs2_pend
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wdata,
        input  lsu_valid, lsu_rd, lsu_wdata,
        input  rs1, rs2, rdata1_in, rdata2_in,
        output alu_ready, lsu_ready,
        output rf_en, rf_rd, rf_wdata,
        output rdata1_out, rdata2_out, rs1_pend, rs2_pend
    );

endinterface

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry writeback holding register; ready whenever empty or being drained this cycle
module wb_slot
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              ready,
    output logic              load,
    output wb_slot_t          slot
);

    always_comb begin
        ready = !slot.valid || grant;
        load  = in_valid && ready;
    end

    // A reload on the grant edge wins over the clear, so the slot stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (load) begin
            slot.valid <= 1'b1;
            slot.rd    <= in_rd;
            slot.data  <= in_data;
        end else if (grant) begin
            slot.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - age-ordered ALU/LSU writeback arbiter with hazard flags; RF_WB_BYPASS_EN adds write-to-read bypass
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_wb_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]  conflict_cnt
);
    import rf_pkg::*;

    wb_slot_t          alu_slot;
    wb_slot_t          lsu_slot;
    wb_slot_t          win_slot;
    logic              alu_load;
    logic              lsu_load;
    logic              alu_grant;
    logic              lsu_grant;
    logic              grant_any;
    logic              both_full;
    req_e              older;
    req_e              older_nxt;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

`ifdef RF_WB_BYPASS_EN
    localparam logic PEND_ON_GRANT = 1'b0;
`else
    localparam logic PEND_ON_GRANT = 1'b1;
`endif

    wb_slot u_alu_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.alu_valid),
        .in_rd    (bus.alu_rd),
        .in_data  (bus.alu_wdata),
        .grant    (alu_grant),
        .ready    (bus.alu_ready),
        .load     (alu_load),
        .slot     (alu_slot)
    );

    wb_slot u_lsu_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.lsu_valid),
        .in_rd    (bus.lsu_rd),
        .in_data  (bus.lsu_wdata),
        .grant    (lsu_grant),
        .ready    (bus.lsu_ready),
        .load     (lsu_load),
        .slot     (lsu_slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older <= REQ_LSU;
        end else begin
            older <= older_nxt;
        end
    end

    // A freshly loaded slot is always the younger one; simultaneous loads leave LSU older.
    always_comb begin
        older_nxt = older;
        if (alu_load) begin
            older_nxt = REQ_LSU;
        end else if (lsu_load) begin
            older_nxt = REQ_ALU;
        end
    end

    always_comb begin
        both_full = alu_slot.valid && lsu_slot.valid;
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (both_full) begin
            lsu_grant = (older == REQ_LSU);
            alu_grant = (older == REQ_ALU);
        end else begin
            alu_grant = alu_slot.valid;
            lsu_grant = lsu_slot.valid;
        end
        grant_any = alu_grant || lsu_grant;
        win_slot  = lsu_grant ? lsu_slot : alu_slot;
        win_rd    = grant_any ? win_slot.rd   : '0;
        win_data  = grant_any ? win_slot.data : '0;
    end

    always_comb begin
        bus.rf_en    = grant_any && (win_rd != '0);
        bus.rf_rd    = win_rd;
        bus.rf_wdata = win_data;
    end

    // Without bypass the granted slot still counts as pending: decode waits for the RF write.
    always_comb begin
        bus.rs1_pend = (bus.rs1 != '0) && (
            (alu_slot.valid && (!alu_grant || PEND_ON_GRANT) && alu_slot.rd == bus.rs1) ||
            (lsu_slot.valid && (!lsu_grant || PEND_ON_GRANT) && lsu_slot.rd == bus.rs1));
        bus.rs2_pend = (bus.rs2 != '0) && (
            (alu_slot.valid && (!alu_grant || PEND_ON_GRANT) && alu_slot.rd == bus.rs2) ||
            (lsu_slot.valid && (!lsu_grant || PEND_ON_GRANT) && lsu_slot.rd == bus.rs2));
    end

`ifdef RF_WB_BYPASS_EN
    always_comb begin
        bus.rdata1_out = (bus.rf_en && bus.rf_rd == bus.rs1) ? bus.rf_wdata : bus.rdata1_in;
        bus.rdata2_out = (bus.rf_en && bus.rf_rd == bus.rs2) ? bus.rf_wdata : bus.rdata2_in;
    end
`else
    always_comb begin
        bus.rdata1_out = bus.rdata1_in;
        bus.rdata2_out = bus.rdata2_in;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (both_full && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed checks of grant order, x0 drop, hazards, async reset and counter saturation
module tb_rf_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] conflict_cnt;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [31:0] rf_mem [32] = '{default: 32'd0};
    logic        saw_stale = 1'b0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    assign bus.rdata1_in = rf_mem[bus.rs1];
    assign bus.rdata2_in = rf_mem[bus.rs2];

    always @(posedge clk) begin
        if (bus.rf_en) begin
            rf_mem[bus.rf_rd] <= bus.rf_wdata;
            if (bus.rf_wdata == 32'hAA || bus.rf_wdata == 32'hBB) saw_stale <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_wdata = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_wdata = '0;
        bus.rs1 = '0; bus.rs2 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        check("reset_rf_en",     32'(bus.rf_en), 0);
        check("reset_rf_rd",     32'(bus.rf_rd), 0);
        check("reset_rf_wdata",  bus.rf_wdata, 0);
        check("reset_alu_ready", 32'(bus.alu_ready), 1);
        check("reset_lsu_ready", 32'(bus.lsu_ready), 1);
        check("reset_cnt",       32'(conflict_cnt), 0);

        // single ALU write
        @(posedge clk); #1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("alu_accept_ready", 32'(bus.alu_ready), 1);
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        @(negedge clk);
        check("alu_wr_en",    32'(bus.rf_en), 1);
        check("alu_wr_rd",    32'(bus.rf_rd), 5);
        check("alu_wr_data",  bus.rf_wdata, 32'hDEADBEEF);
        @(negedge clk);
        check("alu_wr_once",  32'(bus.rf_en), 0);

        // simultaneous same rd: LSU first, ALU last
        @(posedge clk); #1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_wdata = 32'd1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_wdata = 32'd2;
        @(negedge clk);
        check("same_lsu_ready", 32'(bus.lsu_ready), 1);
        @(posedge clk); #1;
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        @(negedge clk);
        check("same_first_data", bus.rf_wdata, 2);
        check("same_first_rd",   32'(bus.rf_rd), 7);
        check("same_cnt0",       32'(conflict_cnt), 0);
        @(negedge clk);
        check("same_second_en",   32'(bus.rf_en), 1);
        check("same_second_data", bus.rf_wdata, 1);
        check("same_cnt1",        32'(conflict_cnt), 1);
        @(negedge clk);
        check("same_idle",  32'(bus.rf_en), 0);
        check("same_final", rf_mem[7], 1);

        // x0 write is consumed without enable
        @(posedge clk); #1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_wdata = 32'hFF;
        @(negedge clk);
        check("x0_ready", 32'(bus.lsu_ready), 1);
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        check("x0_en",    32'(bus.rf_en), 0);
        check("x0_data",  bus.rf_wdata, 32'hFF);
        check("x0_pend",  32'(bus.rs1_pend), 0);
        @(negedge clk);
        check("x0_rdata", bus.rdata1_out, 0);
        check("x0_mem",   rf_mem[0], 0);

        // hazard: ALU rd=3 waits behind LSU rd=9
        @(posedge clk); #1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_wdata = 32'h33;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_wdata = 32'h99;
        bus.rs1 = 5'd3; bus.rs2 = 5'd9;
        @(posedge clk); #1;
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        @(negedge clk);
        check("haz_lsu_rd",   32'(bus.rf_rd), 9);
        check("haz_rs1_pend", 32'(bus.rs1_pend), 1);
`ifdef RF_WB_BYPASS_EN
        check("haz_rs2_pend_byp", 32'(bus.rs2_pend), 0);
        check("haz_rs2_bypass",   bus.rdata2_out, 32'h99);
`else
        check("haz_rs2_pend",     32'(bus.rs2_pend), 1);
`endif
        @(negedge clk);
        check("haz_alu_rd",   32'(bus.rf_rd), 3);
        check("haz_alu_data", bus.rf_wdata, 32'h33);
        check("haz_cnt2",     32'(conflict_cnt), 2);
`ifdef RF_WB_BYPASS_EN
        check("haz_rs1_bypass",   bus.rdata1_out, 32'h33);
        check("haz_rs1_pend_byp", 32'(bus.rs1_pend), 0);
`else
        check("haz_rs1_pend_grant", 32'(bus.rs1_pend), 1);
        check("haz_rs1_rdata",      bus.rdata1_out, 0);
`endif
        bus.rs1 = '0; bus.rs2 = '0;
        @(negedge clk);

        // async reset with both slots full
        @(posedge clk); #1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_wdata = 32'hBB;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_wdata = 32'hAA;
        @(posedge clk); #1;
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_en", 32'(bus.rf_en), 1);
        check("rst_pre_rd", 32'(bus.rf_rd), 10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_en",    32'(bus.rf_en), 0);
        check("rst_async_rd",    32'(bus.rf_rd), 0);
        check("rst_async_cnt",   32'(conflict_cnt), 0);
        check("rst_async_ready", 32'(bus.alu_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_write_10", rf_mem[10], 0);
        check("rst_no_write_11", rf_mem[11], 0);
        check("rst_no_stale",    32'(saw_stale), 0);
        check("rst_idle_en",     32'(bus.rf_en), 0);

        // both requesters streaming: grants alternate, counter saturates at 3
        @(posedge clk); #1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_wdata = 32'h12;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd13; bus.lsu_wdata = 32'h13;
        @(negedge clk);
        check("stream_alu_ready0", 32'(bus.alu_ready), 1);
        check("stream_lsu_ready0", 32'(bus.lsu_ready), 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("stream_lsu_ready", 32'(bus.lsu_ready), (i % 2 == 1) ? 1 : 0);
            check("stream_alu_ready", 32'(bus.alu_ready), (i % 2 == 0) ? 1 : 0);
            check("stream_rf_rd",     32'(bus.rf_rd), (i % 2 == 1) ? 13 : 12);
            if (i == 3) check("stream_cnt2",   32'(conflict_cnt), 2);
            if (i == 6) check("stream_cnt_sat", 32'(conflict_cnt), 3);
        end
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stream_drained", 32'(bus.rf_en), 0);
        check("stream_final13", rf_mem[13], 32'h13);
        check("stream_final12", rf_mem[12], 32'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
